// File: rtl/core_seq_pkg.sv
// Shared constants, state encoding and inst bit map for the core_seq tile sequencer.
package core_seq_pkg;

  localparam int unsigned COL          = 8;
  localparam int unsigned LEN_KIJ      = 9;
  localparam int unsigned LEN_NIJ      = 36;
  localparam int unsigned LEN_ONIJ     = 16;
  localparam int unsigned A_PAD_NI_DIM = 6;
  localparam int unsigned O_NI_DIM     = 4;
  localparam int unsigned KI_DIM       = 3;
  localparam int unsigned GAP          = 10;

  localparam int unsigned INST_W = 35;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned KIJ_W  = 4;
  localparam int unsigned IDX_W  = 4;

  localparam logic [ADDR_W-1:0] W_ADDR_START  = 11'd1024;
  localparam logic [ADDR_W-1:0] W_ADDR_OFFSET = 11'd128;

  localparam int unsigned INST_RELU       = 34;
  localparam int unsigned INST_ACC        = 33;
  localparam int unsigned INST_CEN_PMEM   = 32;
  localparam int unsigned INST_WEN_PMEM   = 31;
  localparam int unsigned INST_A_PMEM_LSB = 20;
  localparam int unsigned INST_CEN_XMEM   = 19;
  localparam int unsigned INST_WEN_XMEM   = 18;
  localparam int unsigned INST_A_XMEM_LSB = 7;
  localparam int unsigned INST_OFIFO_RD   = 6;
  localparam int unsigned INST_IFIFO_WR   = 5;
  localparam int unsigned INST_IFIFO_RD   = 4;
  localparam int unsigned INST_L0_RD      = 3;
  localparam int unsigned INST_L0_WR      = 2;
  localparam int unsigned INST_EXECUTE    = 1;
  localparam int unsigned INST_LOAD       = 0;

  // Both SRAMs disabled and write-inhibited, every strobe low.
  localparam logic [INST_W-1:0] IDLE_INST = 35'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_KRST, S_W_L0, S_W_LD, S_W_GAP, S_A_L0, S_EXEC, S_OF_RD,
    S_ORST, S_ACC_RD, S_RELU, S_OUT, S_DONE
  } state_t;

endpackage

// File: rtl/core_seq_acc_agen.sv
// Output-pixel (o) and kernel-position (j) counters with the accumulation pmem address,
// built from wrapping row/column bases so no divide or multiply is needed.
module core_seq_acc_agen
  import core_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              o_inc,
  input  logic              j_clr,
  input  logic              j_inc,
  output logic [IDX_W-1:0]  o,
  output logic [ADDR_W-1:0] addr_c
);

  logic [IDX_W-1:0]  o_c, k_c;
  logic [ADDR_W-1:0] o_base, k_base, j_base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o      <= '0;
      o_c    <= '0;
      o_base <= '0;
      k_c    <= '0;
      k_base <= '0;
      j_base <= '0;
    end else begin
      if (clr) begin
        o      <= '0;
        o_c    <= '0;
        o_base <= '0;
      end else if (o_inc) begin
        o <= o + IDX_W'(1);
        // End of an output row jumps to the start of the next padded input row.
        if (o_c == IDX_W'(O_NI_DIM - 1)) begin
          o_c    <= '0;
          o_base <= o_base + ADDR_W'(A_PAD_NI_DIM - O_NI_DIM + 1);
        end else begin
          o_c    <= o_c + IDX_W'(1);
          o_base <= o_base + ADDR_W'(1);
        end
      end
      if (clr || j_clr) begin
        k_c    <= '0;
        k_base <= '0;
        j_base <= '0;
      end else if (j_inc) begin
        j_base <= j_base + ADDR_W'(LEN_NIJ);
        if (k_c == IDX_W'(KI_DIM - 1)) begin
          k_c    <= '0;
          k_base <= k_base + ADDR_W'(A_PAD_NI_DIM - KI_DIM + 1);
        end else begin
          k_c    <= k_c + IDX_W'(1);
          k_base <= k_base + ADDR_W'(1);
        end
      end
    end
  end

  assign addr_c = o_base + k_base + j_base;

endmodule

// File: rtl/core_seq.sv
// Sequencer issuing the core inst stream for one 3x3 conv tile: kij loop, then per-output
// accumulate/ReLU loop. Build option CORE_SEQ_RELU_EN drives inst[34] in the RELU cycle.
module core_seq
  import core_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_idx
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic [KIJ_W-1:0]  kij_q, kij_d;
  logic [ADDR_W-1:0] w_base_q, w_base_d, p_base_q, p_base_d;
  logic [INST_W-1:0] inst_d;
  logic              core_reset_d, busy_d, done_d, out_valid_d;
  logic [IDX_W-1:0]  out_idx_d, o;
  logic [ADDR_W-1:0] acc_addr_c;
  logic              agen_clr, o_inc, j_clr, j_inc;

  core_seq_acc_agen u_agen (
    .clk    (clk),
    .rst_n  (reset),
    .clr    (agen_clr),
    .o_inc  (o_inc),
    .j_clr  (j_clr),
    .j_inc  (j_inc),
    .o      (o),
    .addr_c (acc_addr_c)
  );

  // Next state and loop bookkeeping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    kij_d    = kij_q;
    w_base_d = w_base_q;
    p_base_d = p_base_q;
    agen_clr = 1'b0;
    o_inc    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d  = S_KRST;
          kij_d    = '0;
          w_base_d = W_ADDR_START;
          p_base_d = '0;
          agen_clr = 1'b1;
        end
      end
      S_KRST:  begin state_d = S_W_L0; cnt_d = '0; end
      S_W_L0:  if (cnt_q == CNT_W'(COL))         begin state_d = S_W_LD;  cnt_d = '0; end
      S_W_LD:  if (cnt_q == CNT_W'(COL - 1))     begin state_d = S_W_GAP; cnt_d = '0; end
      S_W_GAP: if (cnt_q == CNT_W'(GAP - 1))     begin state_d = S_A_L0;  cnt_d = '0; end
      S_A_L0:  if (cnt_q == CNT_W'(LEN_NIJ))     begin state_d = S_EXEC;  cnt_d = '0; end
      S_EXEC:  if (cnt_q == CNT_W'(LEN_NIJ - 1)) begin state_d = S_OF_RD; cnt_d = '0; end
      S_OF_RD: begin
        // Leave only once the last pmem write is actually on the bus.
        if (!inst[INST_CEN_PMEM] && !inst[INST_WEN_PMEM] && wr_n_q == CNT_W'(LEN_NIJ)) begin
          cnt_d = '0;
          if (kij_q < KIJ_W'(LEN_KIJ - 1)) begin
            state_d  = S_KRST;
            kij_d    = kij_q + KIJ_W'(1);
            w_base_d = w_base_q + W_ADDR_OFFSET;
            p_base_d = p_base_q + ADDR_W'(LEN_NIJ);
          end else begin
            state_d = S_ORST;
          end
        end
      end
      S_ORST:   begin state_d = S_ACC_RD; cnt_d = '0; end
      S_ACC_RD: if (cnt_q == CNT_W'(LEN_KIJ)) begin state_d = S_RELU; cnt_d = '0; end
      S_RELU:   state_d = S_OUT;
      S_OUT: begin
        if (o < IDX_W'(LEN_ONIJ - 1)) begin
          state_d = S_ORST;
          o_inc   = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs for the cycle being entered, registered below.
  always_comb begin
    inst_d       = IDLE_INST;
    inst_d[INST_IFIFO_WR] = 1'b0;
    inst_d[INST_IFIFO_RD] = 1'b0;
    core_reset_d = 1'b0;
    done_d       = 1'b0;
    out_valid_d  = 1'b0;
    out_idx_d    = out_idx;
    busy_d       = (state_d != S_IDLE);
    rd_n_d       = rd_n_q;
    wr_n_d       = wr_n_q;
    j_clr        = 1'b0;
    j_inc        = 1'b0;
    if (state_q == S_KRST) begin
      rd_n_d = '0;
      wr_n_d = '0;
    end
    case (state_d)
      S_KRST, S_ORST: begin
        core_reset_d = 1'b1;
        j_clr        = (state_d == S_ORST);
      end
      S_W_L0: begin
        if (cnt_d < CNT_W'(COL)) begin
          inst_d[INST_CEN_XMEM] = 1'b0;
          inst_d[INST_A_XMEM_LSB +: ADDR_W] = w_base_q + ADDR_W'(cnt_d);
        end
        inst_d[INST_L0_WR] = (cnt_d != '0);
      end
      S_W_LD: begin
        inst_d[INST_L0_RD] = 1'b1;
        inst_d[INST_LOAD]  = 1'b1;
      end
      S_A_L0: begin
        if (cnt_d < CNT_W'(LEN_NIJ)) begin
          inst_d[INST_CEN_XMEM] = 1'b0;
          inst_d[INST_A_XMEM_LSB +: ADDR_W] = ADDR_W'(cnt_d);
        end
        inst_d[INST_L0_WR] = (cnt_d != '0);
      end
      S_EXEC: begin
        inst_d[INST_L0_RD]   = 1'b1;
        inst_d[INST_EXECUTE] = 1'b1;
      end
      S_OF_RD: begin
        if (ofifo_valid && rd_n_q < CNT_W'(LEN_NIJ)) begin
          inst_d[INST_OFIFO_RD] = 1'b1;
          rd_n_d = rd_n_q + CNT_W'(1);
        end
        // A row read last cycle lands in pmem this cycle, stall or not.
        if (inst[INST_OFIFO_RD]) begin
          inst_d[INST_CEN_PMEM] = 1'b0;
          inst_d[INST_WEN_PMEM] = 1'b0;
          inst_d[INST_A_PMEM_LSB +: ADDR_W] = p_base_q + ADDR_W'(wr_n_q);
          wr_n_d = wr_n_q + CNT_W'(1);
        end
      end
      S_ACC_RD: begin
        if (cnt_d < CNT_W'(LEN_KIJ)) begin
          inst_d[INST_CEN_PMEM] = 1'b0;
          inst_d[INST_A_PMEM_LSB +: ADDR_W] = acc_addr_c;
          j_inc = 1'b1;
        end
        inst_d[INST_ACC] = (cnt_d != '0);
      end
      S_RELU: begin
`ifdef CORE_SEQ_RELU_EN
        inst_d[INST_RELU] = 1'b1;
`else
        inst_d[INST_RELU] = 1'b0;
`endif
      end
      S_OUT: begin
        out_valid_d = 1'b1;
        out_idx_d   = o;
      end
      S_DONE:  done_d = 1'b1;
      default: inst_d = IDLE_INST;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      kij_q      <= '0;
      w_base_q   <= W_ADDR_START;
      p_base_q   <= '0;
      rd_n_q     <= '0;
      wr_n_q     <= '0;
      inst       <= IDLE_INST;
      core_reset <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kij_q      <= kij_d;
      w_base_q   <= w_base_d;
      p_base_q   <= p_base_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      inst       <= inst_d;
      core_reset <= core_reset_d;
      busy       <= busy_d;
      done       <= done_d;
      out_valid  <= out_valid_d;
      out_idx    <= out_idx_d;
    end
  end

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq: trace-based reference checks of a full tile under several
// ofifo_valid patterns, table lookups of key addresses, reset and stray-start corner cases.
module tb_core_seq;

  localparam logic [34:0] IDLE_I = 35'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset, start, ofifo_valid;
  logic [34:0] inst;
  logic        core_reset, busy, done, out_valid;
  logic [3:0]  out_idx;

  always #5 clk = ~clk;

  core_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .core_reset  (core_reset),
    .busy        (busy),
    .done        (done),
    .out_valid   (out_valid),
    .out_idx     (out_idx)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Observed trace of one tile.
  int xr[$], pw[$], pr[$], oidx[$], ocyc[$];
  int n_l0wr, n_load, n_exec, n_acc, n_relu, n_crst, n_rd;
  int bad_l0wr, bad_rd, bad_wr, bad_acc;
  int done_cyc;

  // Reference: weights at 1024+kij*128+i (11-bit wrap), then activations 0..35, per kij.
  function automatic int exp_xaddr(int idx);
    int kij = idx / 44;
    int r = idx % 44;
    return (r < 8) ? ((1024 + kij * 128 + r) % 2048) : (r - 8);
  endfunction

  function automatic int exp_paddr(int o, int j);
    return (o / 4) * 6 + (o % 4) + (j / 3) * 6 + (j % 3) + j * 36;
  endfunction

  task automatic run_seq(input int vmode, input bit poke, input string tag);
    bit pv, px, prd, ppr, fin, v;
    int bad;
    xr.delete(); pw.delete(); pr.delete(); oidx.delete(); ocyc.delete();
    n_l0wr = 0; n_load = 0; n_exec = 0; n_acc = 0; n_relu = 0; n_crst = 0; n_rd = 0;
    bad_l0wr = 0; bad_rd = 0; bad_wr = 0; bad_acc = 0; done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    ofifo_valid = 1'b1;
    pv = 1'b1; px = 1'b0; prd = 1'b0; ppr = 1'b0; fin = 1'b0;
    // Cycle 0 holds start; cycle n is observed at the negedge n clocks later.
    for (int cyc = 1; cyc <= 6000 && !fin; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 1) begin
        chk({tag, "_krst_core_reset"}, core_reset, 1);
        chk({tag, "_krst_busy"}, busy, 1);
        chk({tag, "_krst_inst"}, inst, IDLE_I);
      end
      if (!inst[19] && inst[18]) xr.push_back(int'(inst[17:7]));
      if (inst[2]) begin n_l0wr++; if (!px) bad_l0wr++; end
      if (inst[0]) n_load++;
      if (inst[1]) n_exec++;
      if (inst[6]) begin n_rd++; if (!pv) bad_rd++; end
      if (!inst[32] && !inst[31]) begin pw.push_back(int'(inst[30:20])); if (!prd) bad_wr++; end
      if (!inst[32] && inst[31]) pr.push_back(int'(inst[30:20]));
      if (inst[33]) begin n_acc++; if (!ppr) bad_acc++; end
      if (inst[34]) n_relu++;
      if (core_reset) n_crst++;
      if (out_valid) begin oidx.push_back(int'(out_idx)); ocyc.push_back(cyc); end
      if (done) begin
        done_cyc = cyc;
        chk({tag, "_busy_at_done"}, busy, 1);
        fin = 1'b1;
      end
      case (vmode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 3) != 0);
        default: v = (cyc % 2) == 0;
      endcase
      if (poke && !inst[19] && inst[18] && xr.size() == 9) start = 1'b1;
      ofifo_valid = v;
      pv = v;
      px = !inst[19] && inst[18];
      prd = inst[6];
      ppr = !inst[32] && inst[31];
    end
    chk({tag, "_done_seen"}, fin, 1);
    @(negedge clk);
    chk({tag, "_busy_after_done"}, busy, 0);
    chk({tag, "_done_pulse_width"}, done, 0);
    chk({tag, "_inst_idle_after"}, inst, IDLE_I);

    chk({tag, "_xmem_rd_count"}, xr.size(), 9 * 44);
    bad = 0;
    foreach (xr[i]) if (xr[i] != exp_xaddr(i)) bad++;
    chk({tag, "_xmem_rd_addr_seq"}, bad, 0);
    chk({tag, "_pmem_wr_count"}, pw.size(), 9 * 36);
    bad = 0;
    foreach (pw[i]) if (pw[i] != i) bad++;
    chk({tag, "_pmem_wr_consecutive"}, bad, 0);
    chk({tag, "_pmem_rd_count"}, pr.size(), 16 * 9);
    bad = 0;
    foreach (pr[i]) if (pr[i] != exp_paddr(i / 9, i % 9)) bad++;
    chk({tag, "_pmem_rd_addr_seq"}, bad, 0);
    chk({tag, "_l0_wr_count"}, n_l0wr, 9 * (8 + 36));
    chk({tag, "_l0_wr_after_read"}, bad_l0wr, 0);
    chk({tag, "_load_count"}, n_load, 9 * 8);
    chk({tag, "_exec_count"}, n_exec, 9 * 36);
    chk({tag, "_ofifo_rd_count"}, n_rd, 9 * 36);
    chk({tag, "_ofifo_rd_only_on_valid"}, bad_rd, 0);
    chk({tag, "_wr_follows_rd"}, bad_wr, 0);
    chk({tag, "_acc_count"}, n_acc, 16 * 9);
    chk({tag, "_acc_after_read"}, bad_acc, 0);
    chk({tag, "_core_reset_pulses"}, n_crst, 9 + 16);
`ifdef CORE_SEQ_RELU_EN
    chk({tag, "_relu_count"}, n_relu, 16);
`else
    chk({tag, "_relu_count"}, n_relu, 0);
`endif
    chk({tag, "_out_count"}, oidx.size(), 16);
    bad = 0;
    foreach (oidx[i]) begin
      if (oidx[i] != i) bad++;
      if (i > 0 && ocyc[i] - ocyc[i-1] != 13) bad++;
    end
    chk({tag, "_out_idx_and_spacing"}, bad, 0);
    if (vmode == 0) chk({tag, "_done_cycle"}, done_cyc, 1451);
  endtask

  typedef struct { int o; int j; int exp_addr; } acc_vec_t;
  typedef struct { int kij; int i; int exp_addr; } wvec_t;
  acc_vec_t acc_tab[6];
  wvec_t    w_tab[4];

  initial begin
    bit seen;
    acc_tab[0] = '{0, 0, 0};
    acc_tab[1] = '{5, 4, 158};
    acc_tab[2] = '{15, 8, 323};
    acc_tab[3] = '{1, 0, 1};
    acc_tab[4] = '{3, 2, 77};
    acc_tab[5] = '{10, 5, 202};
    w_tab[0]   = '{0, 0, 1024};
    w_tab[1]   = '{3, 0, 1408};
    w_tab[2]   = '{1, 7, 1159};
    w_tab[3]   = '{8, 7, 7};

    reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_inst", inst, IDLE_I);
    chk("rst_core_reset", core_reset, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    reset = 1'b1;
    @(negedge clk);

    run_seq(0, 1'b0, "steady");
    foreach (w_tab[k]) begin
      if (w_tab[k].kij * 44 + w_tab[k].i < xr.size())
        chk($sformatf("w_addr_kij%0d_i%0d", w_tab[k].kij, w_tab[k].i),
            xr[w_tab[k].kij * 44 + w_tab[k].i], w_tab[k].exp_addr);
      else
        chk("w_addr_missing", xr.size(), w_tab[k].kij * 44 + w_tab[k].i + 1);
    end
    foreach (acc_tab[k]) begin
      if (acc_tab[k].o * 9 + acc_tab[k].j < pr.size())
        chk($sformatf("acc_addr_o%0d_j%0d", acc_tab[k].o, acc_tab[k].j),
            pr[acc_tab[k].o * 9 + acc_tab[k].j], acc_tab[k].exp_addr);
      else
        chk("acc_addr_missing", pr.size(), acc_tab[k].o * 9 + acc_tab[k].j + 1);
    end

    run_seq(2, 1'b0, "toggle");
    run_seq(1, 1'b0, "random");
    run_seq(0, 1'b1, "stray_start");

    // Reset in the middle of EXEC, then a clean restart.
    @(negedge clk);
    start = 1'b1;
    ofifo_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 600 && !seen; c++) begin
      @(negedge clk);
      if (inst[1]) seen = 1'b1;
    end
    chk("midexec_reached", seen, 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midexec_rst_inst", inst, IDLE_I);
    chk("midexec_rst_busy", busy, 0);
    chk("midexec_rst_core_reset", core_reset, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midexec_no_resume_inst", inst, IDLE_I);
    chk("midexec_no_resume_busy", busy, 0);
    run_seq(0, 1'b0, "restart");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
